// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: default frame constants and receiver state encoding
package uart_rx_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CLKS_PER_BIT = 1085;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} rx_state_t;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: receiver enable and serial line in, received byte and status out
interface uart_rx_if import uart_rx_pkg::*; #(parameter int DATA_WIDTH = DEF_DATA_WIDTH);
    logic i_rx_en;
    logic i_rx_serial;
    logic [DATA_WIDTH-1:0] o_rx_byte;
    logic o_rx_dv;
    logic o_rx_busy;
    logic o_frame_err;
    modport master (output i_rx_en, i_rx_serial, input o_rx_byte, o_rx_dv, o_rx_busy, o_frame_err);
    modport slave (input i_rx_en, i_rx_serial, output o_rx_byte, o_rx_dv, o_rx_busy, o_frame_err);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchronizer whose flops reset to RESET_VAL
module uart_rx_sync #(
    parameter int WIDTH = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input logic clk,
    input logic rst_n,
    input logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q <= RESET_VAL;
        end else begin
            meta <= d;
            q <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, mid-bit sampling, one-cycle dv / framing-error pulses
module uart_rx import uart_rx_pkg::*; #(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input logic sysclk,
    input logic i_rst_n,
    uart_rx_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);
    rx_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] idx, idx_n;
    logic [DATA_WIDTH-1:0] shift, shift_n, data, data_n;
    logic dv, dv_n, err, err_n, armed, armed_n, rx_s;
    logic [1:0] primed;
    uart_rx_sync #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
        .clk(sysclk), .rst_n(i_rst_n), .d(bus.i_rx_serial), .q(rx_s)
    );
    always_ff @(posedge sysclk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            shift <= '0;
            data <= '0;
            dv <= 1'b0;
            err <= 1'b0;
            armed <= 1'b0;
            primed <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            shift <= shift_n;
            data <= data_n;
            dv <= dv_n;
            err <= err_n;
            armed <= armed_n;
            primed <= {primed[0], 1'b1};
        end
    end
    // The synchronizer's reset-high flops are not real line samples, so arming waits until they have flushed
    always_comb begin
        state_n = state;
        cnt_n = cnt + 1'b1;
        idx_n = idx;
        shift_n = shift;
        data_n = data;
        dv_n = 1'b0;
        err_n = 1'b0;
        armed_n = armed | (state == IDLE && rx_s && primed[1]);
        if (state != IDLE && !bus.i_rx_en) begin
            state_n = IDLE;
            cnt_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (bus.i_rx_en && armed && !rx_s) begin
                        state_n = START;
                        armed_n = 1'b0;
                    end
                end
                START: if (cnt == HALF) begin
                    cnt_n = '0;
                    idx_n = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
                DATA: if (cnt == FULL) begin
                    cnt_n = '0;
                    shift_n[idx] = rx_s;
                    idx_n = idx + 1'b1;
                    state_n = (idx == LAST) ? STOP : DATA;
                end
                STOP: if (cnt == FULL) begin
                    cnt_n = '0;
                    state_n = IDLE;
                    dv_n = rx_s;
                    err_n = !rx_s;
                    data_n = rx_s ? shift : data;
                end
            endcase
        end
    end
    assign bus.o_rx_byte = data;
    assign bus.o_rx_dv = dv;
    assign bus.o_frame_err = err;
    assign bus.o_rx_busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed 8N1 frames with hand-computed bytes, timing and status pulses
module tb_uart_rx;
    localparam int CPB = 16;
    logic sysclk = 1'b0;
    logic i_rst_n = 1'b0;
    uart_rx_if #(.DATA_WIDTH(8)) bus ();
    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (.sysclk(sysclk), .i_rst_n(i_rst_n), .bus(bus));
    always #5 sysclk = ~sysclk;
    int errors = 0;
    int checks = 0;
    logic [7:0] got_q[$];
    longint t_q[$];
    int err_pulses = 0;
    int both = 0;
    int starts = 0;
    int busy_run = 0;
    int max_busy = 0;
    logic busy_d = 1'b0;
    always @(negedge sysclk) begin
        if (bus.o_rx_dv === 1'b1) begin
            got_q.push_back(bus.o_rx_byte);
            t_q.push_back($time);
        end
        if (bus.o_frame_err === 1'b1) err_pulses++;
        if (bus.o_rx_dv === 1'b1 && bus.o_frame_err === 1'b1) both++;
        if (bus.o_rx_busy === 1'b1 && !busy_d) starts++;
        busy_run = (bus.o_rx_busy === 1'b1) ? busy_run + 1 : 0;
        if (busy_run > max_busy) max_busy = busy_run;
        busy_d = (bus.o_rx_busy === 1'b1);
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    function automatic logic [7:0] byte_at(input int i);
        return (i < got_q.size()) ? got_q[i] : 8'hxx;
    endfunction
    function automatic longint time_at(input int i);
        return (i < t_q.size()) ? t_q[i] : -1;
    endfunction
    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(negedge sysclk);
            bus.i_rx_serial = v;
        end
    endtask
    task automatic send(input logic [7:0] b, input logic stop);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        drive(stop, CPB);
    endtask
    initial begin
        int n0, s0, e0;
        longint t0;
        logic [7:0] v;
        bus.i_rx_en = 1'b0;
        bus.i_rx_serial = 1'b1;
        repeat (3) @(negedge sysclk);
        check("rst_byte", bus.o_rx_byte, 8'h00);
        check("rst_dv", bus.o_rx_dv, 1'b0);
        check("rst_err", bus.o_frame_err, 1'b0);
        check("rst_busy", bus.o_rx_busy, 1'b0);
        i_rst_n = 1'b1;
        bus.i_rx_en = 1'b1;
        drive(1'b1, 5);
        n0 = got_q.size();
        e0 = err_pulses;
        t0 = $time + 10;
        send(8'hA5, 1'b1);
        drive(1'b1, 20);
        check("a5_count", got_q.size() - n0, 1);
        check("a5_byte", byte_at(n0), 8'hA5);
        check("a5_err", err_pulses - e0, 0);
        check("a5_latency", ((time_at(n0) - t0) / 10) inside {[154:155]}, 1'b1);
        n0 = got_q.size();
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        drive(1'b1, 20);
        check("b2b_count", got_q.size() - n0, 2);
        check("b2b_first", byte_at(n0), 8'h00);
        check("b2b_second", byte_at(n0 + 1), 8'hFF);
        check("b2b_gap", (time_at(n0 + 1) - time_at(n0)) / 10, 160);
        check("b2b_err", err_pulses - e0, 0);
        n0 = got_q.size();
        max_busy = 0;
        drive(1'b0, 4);
        drive(1'b1, 40);
        check("glitch_busy_short", max_busy > 0 && max_busy < CPB, 1'b1);
        check("glitch_dv", got_q.size() - n0, 0);
        check("glitch_err", err_pulses - e0, 0);
        send(8'h3C, 1'b1);
        drive(1'b1, 20);
        check("after_glitch_byte", byte_at(n0), 8'h3C);
        n0 = got_q.size();
        s0 = starts;
        send(8'h5A, 1'b0);
        drive(1'b0, 40);
        drive(1'b1, 40);
        check("ferr_pulse", err_pulses - e0, 1);
        check("ferr_dv", got_q.size() - n0, 0);
        check("ferr_byte_held", bus.o_rx_byte, 8'h3C);
        check("ferr_no_retrigger", starts - s0, 1);
        send(8'h81, 1'b1);
        drive(1'b1, 20);
        check("after_ferr_byte", byte_at(n0), 8'h81);
        n0 = got_q.size();
        v = 8'h77;
        drive(1'b0, CPB);
        for (int i = 0; i < 3; i++) drive(v[i], CPB);
        drive(v[3], 8);
        check("abort_busy_before", bus.o_rx_busy, 1'b1);
        bus.i_rx_en = 1'b0;
        @(negedge sysclk);
        check("abort_busy_after", bus.o_rx_busy, 1'b0);
        drive(v[3], 7);
        for (int i = 4; i < 8; i++) drive(v[i], CPB);
        drive(1'b1, CPB + 20);
        check("abort_dv", got_q.size() - n0, 0);
        bus.i_rx_en = 1'b1;
        drive(1'b1, 5);
        send(8'h12, 1'b1);
        drive(1'b1, 20);
        check("after_abort_byte", byte_at(n0), 8'h12);
        n0 = got_q.size() + 0;
        n0 = got_q.size();
        e0 = err_pulses;
        v = 8'h1F;
        drive(1'b0, CPB);
        for (int i = 0; i < 5; i++) drive(v[i], CPB);
        drive(v[5], 8);
        i_rst_n = 1'b0;
        @(negedge sysclk);
        check("mrst_byte", bus.o_rx_byte, 8'h00);
        check("mrst_dv", bus.o_rx_dv, 1'b0);
        check("mrst_err", bus.o_frame_err, 1'b0);
        check("mrst_busy", bus.o_rx_busy, 1'b0);
        i_rst_n = 1'b1;
        drive(v[5], 7);
        for (int i = 6; i < 8; i++) drive(v[i], CPB);
        drive(1'b1, CPB + 30);
        check("mrst_no_dv", got_q.size() - n0, 0);
        check("mrst_no_err", err_pulses - e0, 0);
        send(8'h4E, 1'b1);
        drive(1'b1, 20);
        check("after_mrst_byte", byte_at(n0), 8'h4E);
        check("total_frames", got_q.size(), 7);
        check("dv_err_exclusive", both, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
